// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the data-RAM port arbiter: default sizes, FSM state
// encoding and requester IDs.
package ram_arb_pkg;

    localparam int ARB_AW = 12;
    localparam int ARB_DW = 16;

    typedef logic [0:0] arb_state_t;

    localparam arb_state_t ARB_IDLE  = 1'b0;
    localparam arb_state_t ARB_CLEAR = 1'b1;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_IO  = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of requester handshakes, clear control and RAM-side signals.
// The arbiter takes the slave modport; the environment takes the master modport.
interface ram_port_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int AW = ARB_AW,
    parameter int DW = ARB_DW
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          io_req;
    logic          io_we;
    logic [AW-1:0] io_addr;
    logic [DW-1:0] io_wdata;
    logic          io_gnt;
    logic          io_rvalid;
    logic [DW-1:0] io_rdata;

    logic          clr_start;
    logic          clr_busy;
    logic          clr_done;

    logic          ram_cs;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  io_req, io_we, io_addr, io_wdata,
        output io_gnt, io_rvalid, io_rdata,
        input  clr_start,
        output clr_busy, clr_done,
        output ram_cs, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output io_req, io_we, io_addr, io_wdata,
        input  io_gnt, io_rvalid, io_rdata,
        output clr_start,
        input  clr_busy, clr_done,
        input  ram_cs, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way grant generator: round-robin on a last-grant pointer, or fixed CPU
// priority when FIXED_PRIO=1. Grants are combinational from req.
module rr_arbiter2
    import ram_arb_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       res,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        if (en) begin
            if (req[REQ_CPU] && req[REQ_IO]) begin
                if (FIXED_PRIO || (last_q == REQ_IO)) begin
                    gnt[REQ_CPU] = 1'b1;
                end else begin
                    gnt[REQ_IO] = 1'b1;
                end
            end else begin
                gnt = req;
            end
            if (gnt[REQ_CPU]) begin
                last_d = REQ_CPU;
            end else if (gnt[REQ_IO]) begin
                last_d = REQ_IO;
            end
        end
    end

    // Pointer starts at "I/O granted last" so the CPU wins the first tie.
    always_ff @(posedge clk) begin
        if (res) begin
            last_q <= REQ_IO;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single-port data RAM between the CPU and the I/O scanner, and
// runs a synchronous zero-fill sweep of the whole array on request.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW         = ARB_AW,
    parameter int DW         = ARB_DW,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                clk,
    input  logic                res,
    ram_port_arbiter_if.slave   bus
);

    localparam logic [AW:0] LAST_ADDR = {1'b0, {AW{1'b1}}};
    localparam logic [AW:0] CNT_ONE   = {{AW{1'b0}}, 1'b1};

    arb_state_t  state_q, state_d;
    logic [AW:0] cnt_q, cnt_d;
    logic        clr_done_q, clr_done_d;
    logic        cpu_rd_q, cpu_rd_d;
    logic        io_rd_q, io_rd_d;

    logic        arb_en;
    logic [1:0]  req_vec;
    logic [1:0]  gnt_vec;

    // The clr_done cycle is kept grant-free so held requests resume one cycle later.
    assign arb_en = !res && (state_q == ARB_IDLE) && !clr_done_q;

    always_comb begin
        req_vec          = 2'b00;
        req_vec[REQ_CPU] = bus.cpu_req;
        req_vec[REQ_IO]  = bus.io_req;
    end

    rr_arbiter2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_rr (
        .clk (clk),
        .res (res),
        .en  (arb_en),
        .req (req_vec),
        .gnt (gnt_vec)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_done_d = 1'b0;
        if (state_q == ARB_IDLE) begin
            if (bus.clr_start) begin
                state_d = ARB_CLEAR;
                cnt_d   = '0;
            end
        end else begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == LAST_ADDR) begin
                state_d    = ARB_IDLE;
                clr_done_d = 1'b1;
            end
        end
    end

    always_comb begin
        cpu_rd_d = gnt_vec[REQ_CPU] && !bus.cpu_we;
        io_rd_d  = gnt_vec[REQ_IO]  && !bus.io_we;
    end

    always_comb begin
        bus.ram_cs    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        if (!res && (state_q == ARB_CLEAR)) begin
            bus.ram_cs    = 1'b1;
            bus.ram_we    = 1'b1;
            bus.ram_addr  = cnt_q[AW-1:0];
        end else if (gnt_vec[REQ_CPU]) begin
            bus.ram_cs    = 1'b1;
            bus.ram_we    = bus.cpu_we;
            bus.ram_addr  = bus.cpu_addr;
            bus.ram_wdata = bus.cpu_wdata;
        end else if (gnt_vec[REQ_IO]) begin
            bus.ram_cs    = 1'b1;
            bus.ram_we    = bus.io_we;
            bus.ram_addr  = bus.io_addr;
            bus.ram_wdata = bus.io_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= ARB_IDLE;
            cnt_q      <= '0;
            clr_done_q <= 1'b0;
            cpu_rd_q   <= 1'b0;
            io_rd_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_done_q <= clr_done_d;
            cpu_rd_q   <= cpu_rd_d;
            io_rd_q    <= io_rd_d;
        end
    end

    assign bus.cpu_gnt    = gnt_vec[REQ_CPU];
    assign bus.io_gnt     = gnt_vec[REQ_IO];
    assign bus.cpu_rvalid = cpu_rd_q;
    assign bus.io_rvalid  = io_rd_q;
    assign bus.cpu_rdata  = bus.ram_rdata;
    assign bus.io_rdata   = bus.ram_rdata;
    assign bus.clr_busy   = (state_q == ARB_CLEAR);
    assign bus.clr_done   = clr_done_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench: two arbiters (round-robin and fixed priority), each with
// its own behavioural RAM; read returns are checked by decoupled monitors.
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    typedef struct packed {
        logic        port;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic res;
    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sq0[$];
    exp_t sq1[$];
    exp_t e0, e1;
    logic [15:0] mem0 [4096];
    logic [15:0] mem1 [4096];

    always #5 clk = ~clk;

    ram_port_arbiter_if #(.AW(12), .DW(16)) b0 ();
    ram_port_arbiter_if #(.AW(12), .DW(16)) b1 ();

    ram_port_arbiter #(.AW(12), .DW(16), .FIXED_PRIO(1'b0)) u0 (.clk(clk), .res(res), .bus(b0));
    ram_port_arbiter #(.AW(12), .DW(16), .FIXED_PRIO(1'b1)) u1 (.clk(clk), .res(res), .bus(b1));

    always @(posedge clk) begin
        if (b0.ram_cs) begin
            if (b0.ram_we) mem0[b0.ram_addr] <= b0.ram_wdata;
            else           b0.ram_rdata      <= mem0[b0.ram_addr];
        end
        if (b1.ram_cs) begin
            if (b1.ram_we) mem1[b1.ram_addr] <= b1.ram_wdata;
            else           b1.ram_rdata      <= mem1[b1.ram_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (b0.cpu_rvalid || b0.io_rvalid) begin
            if (sq0.size() == 0) begin
                chk("sb0_spurious_rvalid", {b0.cpu_rvalid, b0.io_rvalid}, 0);
            end else begin
                e0 = sq0.pop_front();
                chk("sb0_port", {b0.cpu_rvalid, b0.io_rvalid}, e0.port ? 2'b01 : 2'b10);
                chk("sb0_data", e0.port ? b0.io_rdata : b0.cpu_rdata, e0.data);
            end
        end
    end

    always @(negedge clk) begin
        if (b1.cpu_rvalid || b1.io_rvalid) begin
            if (sq1.size() == 0) begin
                chk("sb1_spurious_rvalid", {b1.cpu_rvalid, b1.io_rvalid}, 0);
            end else begin
                e1 = sq1.pop_front();
                chk("sb1_port", {b1.cpu_rvalid, b1.io_rvalid}, e1.port ? 2'b01 : 2'b10);
                chk("sb1_data", e1.port ? b1.io_rdata : b1.cpu_rdata, e1.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single access on dut0; waits (bounded) for the grant.
    task automatic acc0(input logic port, input logic we, input logic [11:0] a,
                        input logic [15:0] d, input logic [15:0] exp_rd, input string nm);
        logic got;
        got = 1'b0;
        if (port == REQ_CPU) begin
            b0.cpu_req = 1'b1; b0.cpu_we = we; b0.cpu_addr = a; b0.cpu_wdata = d;
        end else begin
            b0.io_req = 1'b1; b0.io_we = we; b0.io_addr = a; b0.io_wdata = d;
        end
        for (int c = 0; c < 6000 && !got; c++) begin
            @(negedge clk);
            got = (port == REQ_CPU) ? b0.cpu_gnt : b0.io_gnt;
            if (got) begin
                chk({nm, "_other_gnt"}, (port == REQ_CPU) ? b0.io_gnt : b0.cpu_gnt, 0);
                chk({nm, "_ram_addr"}, b0.ram_addr, a);
                chk({nm, "_ram_we"}, b0.ram_we, we);
                if (we) chk({nm, "_ram_wdata"}, b0.ram_wdata, d);
                else    sq0.push_back('{port, exp_rd});
            end
            tick();
        end
        chk({nm, "_gnt"}, got, 1);
        b0.cpu_req = 1'b0;
        b0.io_req  = 1'b0;
    endtask

    task automatic acc1(input logic port, input logic we, input logic [11:0] a,
                        input logic [15:0] d, input string nm);
        logic got;
        got = 1'b0;
        if (port == REQ_CPU) begin
            b1.cpu_req = 1'b1; b1.cpu_we = we; b1.cpu_addr = a; b1.cpu_wdata = d;
        end else begin
            b1.io_req = 1'b1; b1.io_we = we; b1.io_addr = a; b1.io_wdata = d;
        end
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = (port == REQ_CPU) ? b1.cpu_gnt : b1.io_gnt;
            tick();
        end
        chk({nm, "_gnt"}, got, 1);
        b1.cpu_req = 1'b0;
        b1.io_req  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int addr_err;
        logic seen;

        res = 1'b1;
        b0.cpu_req = 1'b1; b0.cpu_we = 1'b0; b0.cpu_addr = '0; b0.cpu_wdata = '0;
        b0.io_req  = 1'b1; b0.io_we  = 1'b0; b0.io_addr  = '0; b0.io_wdata  = '0;
        b0.clr_start = 1'b0;
        b1.cpu_req = 1'b1; b1.cpu_we = 1'b0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
        b1.io_req  = 1'b1; b1.io_we  = 1'b0; b1.io_addr  = '0; b1.io_wdata  = '0;
        b1.clr_start = 1'b0;

        // Reset held two cycles with both requesters active.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_gnt0", {b0.cpu_gnt, b0.io_gnt}, 0);
            chk("rst_gnt1", {b1.cpu_gnt, b1.io_gnt}, 0);
            chk("rst_cs", {b0.ram_cs, b1.ram_cs}, 0);
            chk("rst_rvalid", {b0.cpu_rvalid, b0.io_rvalid, b1.cpu_rvalid, b1.io_rvalid}, 0);
            chk("rst_busy", {b0.clr_busy, b0.clr_done}, 0);
        end
        tick();
        res = 1'b0;
        b0.cpu_req = 1'b0; b0.io_req = 1'b0;
        b1.cpu_req = 1'b0; b1.io_req = 1'b0;
        tick();

        // CPU alone: write then read back.
        acc0(REQ_CPU, 1'b1, 12'h001, 16'hBEEF, 16'h0000, "cpu_wr");
        acc0(REQ_CPU, 1'b0, 12'h001, 16'h0000, 16'hBEEF, "cpu_rd");

        // Round robin: last preload by I/O so the first tie goes to the CPU.
        acc0(REQ_IO, 1'b1, 12'h010, 16'h1010, 16'h0000, "io_wr");
        b0.cpu_req = 1'b1; b0.cpu_we = 1'b0; b0.cpu_addr = 12'h010;
        b0.io_req  = 1'b1; b0.io_we  = 1'b0; b0.io_addr  = 12'h001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rr_cpu_gnt%0d", i), b0.cpu_gnt, (i % 2 == 0));
            chk($sformatf("rr_io_gnt%0d", i), b0.io_gnt, (i % 2 == 1));
            if (b0.cpu_gnt) sq0.push_back('{REQ_CPU, 16'h1010});
            if (b0.io_gnt)  sq0.push_back('{REQ_IO, 16'hBEEF});
            tick();
        end
        b0.cpu_req = 1'b0; b0.io_req = 1'b0;
        tick();

        // Fixed priority on dut1.
        acc1(REQ_CPU, 1'b1, 12'h010, 16'h2020, "fp_cpu_wr");
        acc1(REQ_IO,  1'b1, 12'h001, 16'h3030, "fp_io_wr");
        b1.cpu_req = 1'b1; b1.cpu_we = 1'b0; b1.cpu_addr = 12'h010;
        b1.io_req  = 1'b1; b1.io_we  = 1'b0; b1.io_addr  = 12'h001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("fp_gnt%0d", i), {b1.cpu_gnt, b1.io_gnt}, 2'b10);
            if (b1.cpu_gnt) sq1.push_back('{REQ_CPU, 16'h2020});
            if (b1.io_gnt)  sq1.push_back('{REQ_IO, 16'h3030});
            tick();
        end
        b1.cpu_req = 1'b0;
        @(negedge clk);
        chk("fp_io_after_cpu_drop", {b1.cpu_gnt, b1.io_gnt}, 2'b01);
        if (b1.io_gnt) sq1.push_back('{REQ_IO, 16'h3030});
        tick();
        b1.io_req = 1'b0;
        tick();

        // Full clear sweep with a CPU read held throughout and a stray clr_start.
        acc0(REQ_CPU, 1'b1, 12'h123, 16'h5A5A, 16'h0000, "pre_123");
        acc0(REQ_CPU, 1'b1, 12'hFFF, 16'h5A5A, 16'h0000, "pre_fff");
        b0.clr_start = 1'b1;
        tick();
        b0.clr_start = 1'b0;
        b0.cpu_req = 1'b1; b0.cpu_we = 1'b0; b0.cpu_addr = 12'h123;
        busy_cnt = 0;
        addr_err = 0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (!b0.clr_busy) break;
            if (b0.ram_addr !== busy_cnt[11:0] || b0.ram_cs !== 1'b1 || b0.ram_we !== 1'b1 ||
                b0.ram_wdata !== 16'h0000 || b0.cpu_gnt !== 1'b0 || b0.clr_done !== 1'b0)
                addr_err++;
            busy_cnt++;
            tick();
            b0.clr_start = (busy_cnt == 1000);
        end
        chk("clr_busy_len", busy_cnt, 4096);
        chk("clr_sweep_errs", addr_err, 0);
        chk("clr_done_pulse", b0.clr_done, 1);
        chk("clr_done_no_gnt", b0.cpu_gnt, 0);
        tick();
        @(negedge clk);
        chk("clr_done_width", b0.clr_done, 0);
        chk("clr_pending_gnt", b0.cpu_gnt, 1);
        if (b0.cpu_gnt) sq0.push_back('{REQ_CPU, 16'h0000});
        tick();
        b0.cpu_req = 1'b0;
        acc0(REQ_CPU, 1'b0, 12'hFFF, 16'h0000, 16'h0000, "clr_rd_fff");

        // Reset arriving when the sweep reaches 0x200.
        acc0(REQ_CPU, 1'b1, 12'h1FF, 16'h7777, 16'h0000, "pre_1ff");
        acc0(REQ_IO,  1'b1, 12'h300, 16'h3333, 16'h0000, "pre_300");
        b0.clr_start = 1'b1;
        tick();
        b0.clr_start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            @(negedge clk);
            seen = b0.clr_busy && (b0.ram_addr == 12'h1FF);
            tick();
        end
        chk("rstclr_reached_1ff", seen, 1);
        res = 1'b1;
        @(negedge clk);
        chk("rstclr_cs", b0.ram_cs, 0);
        tick();
        res = 1'b0;
        @(negedge clk);
        chk("rstclr_busy", b0.clr_busy, 0);
        chk("rstclr_done", b0.clr_done, 0);
        tick();
        @(negedge clk);
        chk("rstclr_done_late", {b0.clr_busy, b0.clr_done}, 0);
        tick();
        acc0(REQ_CPU, 1'b0, 12'h1FF, 16'h0000, 16'h0000, "rstclr_rd_1ff");
        acc0(REQ_CPU, 1'b0, 12'h300, 16'h0000, 16'h3333, "rstclr_rd_300");

        tick();
        tick();
        chk("sb0_drained", sq0.size(), 0);
        chk("sb1_drained", sq1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
